// File: rtl/aes_result_buffer_pkg.sv
// rtl/aes_result_buffer_pkg.sv - shared job type and default depth for the AES result buffer
package aes_result_buffer_pkg;

  localparam int AES_RESULT_DEPTH = 8;

  typedef enum logic [1:0] {
    INVALID = 2'd0,
    ENCRYPT = 2'd1,
    DECRYPT = 2'd2
  } job_t;

endpackage

// File: rtl/aes_result_fifo.sv
// rtl/aes_result_fifo.sv - result storage, pointers and count with registered head
// Optional build macro: AES_RESULT_ZEROIZE_EN (clears vacated and flushed entries).
module aes_result_fifo
  import aes_result_buffer_pkg::*;
#(
  parameter int DEPTH = AES_RESULT_DEPTH,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [127:0]  push_data,
  input  job_t          push_type,
  input  logic          pop,
  input  logic          flush,
  output logic          valid,
  output logic [127:0]  head_data,
  output job_t          head_type,
  output logic [CW-1:0] count,
  output logic          full
);

  localparam int AW = $clog2(DEPTH);

  logic [127:0]  mem_data [DEPTH];
  job_t          mem_type [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt;
  logic [CW-1:0] cnt_nxt;
  logic [127:0]  head_q;
  logic          do_push, do_pop, bypass;

  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && valid && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign rd_nxt  = rd_ptr + AW'(do_pop);
  assign cnt_nxt = count + CW'(do_push) - CW'(do_pop);
  // The word being written lands directly at the head when nothing older remains.
  assign bypass  = do_push && ((count - CW'(do_pop)) == '0);

  always_ff @(posedge clk) begin
`ifdef AES_RESULT_ZEROIZE_EN
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) mem_data[i] <= '0;
    end else if (do_pop) begin
      mem_data[rd_ptr] <= '0;
    end
`endif
    if (do_push) begin
      mem_data[wr_ptr] <= push_data;
      mem_type[wr_ptr] <= push_type;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      valid     <= 1'b0;
      head_q    <= '0;
      head_type <= INVALID;
    end else if (flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      valid     <= 1'b0;
      head_type <= INVALID;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_nxt;
      count  <= cnt_nxt;
      valid  <= (cnt_nxt != '0);
      if (cnt_nxt != '0) begin
        head_q    <= bypass ? push_data : mem_data[rd_nxt];
        head_type <= bypass ? push_type : mem_type[rd_nxt];
      end
    end
  end

`ifdef AES_RESULT_ZEROIZE_EN
  assign head_data = valid ? head_q : '0;
`else
  assign head_data = head_q;
`endif

endmodule

// File: rtl/aes_result_buffer.sv
// rtl/aes_result_buffer.sv - AES last-round result FIFO with issue credit counter and sticky errors
// Optional build macro: AES_RESULT_ZEROIZE_EN (handled inside aes_result_fifo).
module aes_result_buffer
  import aes_result_buffer_pkg::*;
#(
  parameter int DEPTH = AES_RESULT_DEPTH,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue,
  output logic          issue_ok,
  input  logic [127:0]  res_data,
  input  job_t          res_type,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_data,
  output job_t          out_type,
  output logic [CW-1:0] count,
  output logic [1:0]    err
);

  logic [CW-1:0] inflight;
  logic [CW:0]   occupancy;
  logic          push, pop, full, accepted;

  assign push      = (res_type != INVALID);
  assign pop       = out_valid && out_ready;
  assign occupancy = {1'b0, count} + {1'b0, inflight};
  assign issue_ok  = (occupancy < (CW+1)'(DEPTH));
  assign accepted  = issue && issue_ok;

  aes_result_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (res_data),
    .push_type (res_type),
    .pop       (out_ready),
    .flush     (flush),
    .valid     (out_valid),
    .head_data (out_data),
    .head_type (out_type),
    .count     (count),
    .full      (full)
  );

  // A push with no job in flight is a protocol error; the counter saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
      err      <= 2'b00;
    end else begin
      if (accepted && !push) begin
        inflight <= inflight + CW'(1);
      end else if (!accepted && push && (inflight != '0)) begin
        inflight <= inflight - CW'(1);
      end
      if ((issue && !issue_ok) || (push && (inflight == '0))) err[1] <= 1'b1;
      if (push && full && !pop && !flush) err[0] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_result_buffer.sv
// tb/tb_aes_result_buffer.sv - scoreboard bench for aes_result_buffer (DEPTH 8)
module tb_aes_result_buffer;
  import aes_result_buffer_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          issue = 1'b0;
  logic          issue_ok;
  logic [127:0]  res_data = '0;
  job_t          res_type = INVALID;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [127:0]  out_data;
  job_t          out_type;
  logic [CW-1:0] count;
  logic [1:0]    err;

  aes_result_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .issue(issue), .issue_ok(issue_ok),
    .res_data(res_data), .res_type(res_type), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_type(out_type), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    job_t         t;
    logic [127:0] d;
  } ent_t;

  ent_t       q[$];
  int         m_infl = 0;
  logic [1:0] m_err = 2'b00;
  int         n_checks = 0;
  int         n_err = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model, then compare the DUT's registered state.
  task automatic cyc(input logic iss, input job_t t, input logic [127:0] d,
                     input logic rdy, input logic fl);
    int   sz;
    bit   popped, ok, psh;
    ent_t e;
    sz     = q.size();
    popped = (sz > 0) && rdy && !fl;
    ok     = (sz + m_infl) < DEPTH;
    psh    = (t != INVALID);
    issue = iss; res_type = t; res_data = d; out_ready = rdy; flush = fl;
    if (popped) begin
      check("pop_data", out_data, q[0].d);
      check("pop_type", 128'(out_type), 128'(q[0].t));
    end
    if (iss && !ok) m_err[1] = 1'b1;
    if (psh && m_infl == 0) m_err[1] = 1'b1;
    if (fl) begin
      q.delete();
    end else begin
      if (popped) void'(q.pop_front());
      if (psh) begin
        if (sz < DEPTH || popped) begin
          e.t = t; e.d = d; q.push_back(e);
        end else begin
          m_err[0] = 1'b1;
        end
      end
    end
    if (iss && ok && !psh) m_infl++;
    else if (!(iss && ok) && psh && m_infl > 0) m_infl--;
    @(posedge clk); #1;
    issue = 1'b0; res_type = INVALID; out_ready = 1'b0; flush = 1'b0;
    check("count", 128'(count), 128'(q.size()));
    check("out_valid", 128'(out_valid), 128'(q.size() > 0));
    check("issue_ok", 128'(issue_ok), 128'((q.size() + m_infl) < DEPTH));
    check("err", 128'(err), 128'(m_err));
    check("inflight", 128'(dut.inflight), 128'(m_infl));
    if (q.size() > 0) begin
      check("head_data", out_data, q[0].d);
      check("head_type", 128'(out_type), 128'(q[0].t));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, INVALID, '0, 1'b0, 1'b0);
  endtask

  logic [127:0] kat;
  logic [127:0] rnd;
  job_t         jt;

  initial begin
    kat = 128'h3925841d02dc09fbdc118597196a0b32;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_type", 128'(out_type), 128'(INVALID));
    check("rst_out_data", out_data, 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_count", 128'(count), 128'(0));
    check("rst_issue_ok", 128'(issue_ok), 128'(1));
    check("rst_err", 128'(err), 128'(0));

    // Single job
    cyc(1'b1, INVALID, '0, 1'b0, 1'b0);
    idle(10);
    cyc(1'b0, ENCRYPT, kat, 1'b0, 1'b0);
    check("single_valid", 128'(out_valid), 128'(1));
    check("single_data", out_data, kat);
    cyc(1'b0, INVALID, '0, 1'b1, 1'b0);
    check("single_count", 128'(count), 128'(0));
    check("single_inflight", 128'(dut.inflight), 128'(0));

    // Credit limit
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, INVALID, '0, 1'b0, 1'b0);
    check("credit_full", 128'(issue_ok), 128'(0));
    cyc(1'b1, INVALID, '0, 1'b0, 1'b0);
    check("credit_err1", 128'(err[1]), 128'(1));
    cyc(1'b0, DECRYPT, 128'hA5, 1'b0, 1'b0);
    cyc(1'b0, INVALID, '0, 1'b1, 1'b0);
    check("credit_release", 128'(issue_ok), 128'(1));

    // Backpressure
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b0, (i % 2) ? DECRYPT : ENCRYPT, {96'h0, 32'(i + 16'h100)}, 1'b0, 1'b0);
    check("bp_count8", 128'(count), 128'(8));
    cyc(1'b0, ENCRYPT, 128'hBEEF, 1'b1, 1'b0);
    check("bp_pushpop", 128'(count), 128'(8));
    check("bp_no_ovf", 128'(err[0]), 128'(0));
    cyc(1'b0, DECRYPT, 128'hDEAD, 1'b0, 1'b0);
    check("bp_ovf", 128'(err[0]), 128'(1));
    check("bp_count_after", 128'(count), 128'(8));

    // Flush
    for (int i = 0; i < 5; i++) cyc(1'b0, INVALID, '0, 1'b1, 1'b0);
    cyc(1'b1, INVALID, '0, 1'b0, 1'b0);
    cyc(1'b1, INVALID, '0, 1'b0, 1'b0);
    check("flush_pre_count", 128'(count), 128'(3));
    cyc(1'b0, INVALID, '0, 1'b1, 1'b1);
    check("flush_count", 128'(count), 128'(0));
    check("flush_valid", 128'(out_valid), 128'(0));
    check("flush_inflight", 128'(dut.inflight), 128'(2));
`ifdef AES_RESULT_ZEROIZE_EN
    check("zero_out_data", out_data, 128'(0));
    for (int i = 0; i < DEPTH; i++) check("zero_mem", dut.u_fifo.mem_data[i], 128'(0));
`endif
    cyc(1'b0, ENCRYPT, 128'h1111, 1'b0, 1'b0);
    cyc(1'b0, DECRYPT, 128'h2222, 1'b1, 1'b1);
    check("flush_discard", 128'(count), 128'(0));

    // Mixed types at full throughput
    for (int i = 0; i < 18; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      jt  = (i % 3 == 2) ? INVALID : ((i % 2 == 1) ? DECRYPT : ENCRYPT);
      cyc(i % 2 == 0, jt, rnd, 1'b1, 1'b0);
    end
    cyc(1'b0, INVALID, '0, 1'b1, 1'b0);
    cyc(1'b0, INVALID, '0, 1'b1, 1'b0);
    check("mixed_drained", 128'(count), 128'(0));

    // Asynchronous reset mid-operation
    cyc(1'b1, ENCRYPT, 128'h77, 1'b0, 1'b0);
    cyc(1'b0, DECRYPT, 128'h88, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", 128'(count), 128'(0));
    check("arst_valid", 128'(out_valid), 128'(0));
    check("arst_err", 128'(err), 128'(0));
    check("arst_issue_ok", 128'(issue_ok), 128'(1));
    q.delete(); m_infl = 0; m_err = 2'b00;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(1'b1, INVALID, '0, 1'b0, 1'b0);
    cyc(1'b0, ENCRYPT, 128'h99, 1'b0, 1'b0);
    cyc(1'b0, INVALID, '0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
